// File: rtl/game_timer_fnd_pkg.sv
// Shared types and constants for the BCD game timer: FSM state encoding,
// BCD limits, the blank segment pattern and the seven-segment digit table.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package game_timer_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Seven-segment digit table; non-BCD codes never reach it and show blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Preload digits above 9 saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/game_timer_fnd_bcd_digit_cell.sv
// One BCD digit of the timer: clear, clamped load, and a +1/-1 step with
// carry (9 -> 0) or borrow (0 -> 9) out to the next digit up.
module bcd_digit_cell
  import game_timer_fnd_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Clear,
  input  logic       i_Load,
  input  logic [3:0] i_LoadVal,
  input  logic       i_Step,
  input  logic       i_Down,
  output logic [3:0] o_Digit,
  output logic [3:0] o_DigitNext,
  output logic       o_Carry
);

  logic [3:0] digit_q, digit_d;
  logic       carry;

  // Next digit value and carry/borrow out; clear beats load beats step.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    digit_d = digit_q;
    carry   = 1'b0;
    if (i_Clear) begin
      digit_d = 4'd0;
    end else if (i_Load) begin
      digit_d = bcd_clamp(i_LoadVal);
    end else if (i_Step) begin
      if (i_Down) begin
        if (digit_q == 4'd0) begin
          digit_d = BCD_MAX;
          carry   = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end else begin
        if (digit_q >= BCD_MAX) begin
          digit_d = 4'd0;
          carry   = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge i_Clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (i_Rst) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

  assign o_Digit     = digit_q;
  assign o_DigitNext = digit_d;
  assign o_Carry     = carry;

endmodule

// File: rtl/game_timer_fnd.sv
// Parametrised BCD game timer with start/stop/clear/load control, up/down
// counting, terminal-count detection and seven-segment outputs.
// Optional GAME_TIMER_LZB_EN: leading-zero blanking on o_FND (digit 0 always shown).
module game_timer_fnd
  import game_timer_fnd_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int TICK_CLKS = 50_000_000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic                  i_Stop,
  input  logic                  i_Clear,
  input  logic                  i_Load,
  input  logic [4*DIGITS-1:0]   i_LoadVal,
  input  logic                  i_Down,
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic [7*DIGITS-1:0]   o_FND,
  output logic                  o_Run,
  output logic                  o_Done,
  output logic                  o_Tick
);

  localparam int               PRE_W   = $clog2(TICK_CLKS);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CLKS - 1);

  state_e                   state_q, state_d;
  logic [PRE_W-1:0]         presc_q, presc_d;
  logic                     down_q, down_d;

  logic [DIGITS-1:0][3:0]   bcd, bcd_nxt;
  logic [DIGITS:0]          step;
  logic [DIGITS-1:0][6:0]   fnd;
  logic                     tick, cnt_max, nxt_max, cnt_zero, nxt_zero;

  // A step fires at the end of each prescaler period in RUN unless a
  // higher-priority command takes the cycle.
  assign tick    = (state_q == RUN) && (presc_q == PRE_MAX) && !i_Clear && !i_Load && !i_Stop;
  assign step[0] = tick;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_Clear     (i_Clear),
      .i_Load      (i_Load),
      .i_LoadVal   (i_LoadVal[4*k +: 4]),
      .i_Step      (step[k]),
      .i_Down      (down_q),
      .o_Digit     (bcd[k]),
      .o_DigitNext (bcd_nxt[k]),
      .o_Carry     (step[k+1])
    );
  end

  // Terminal-count flags for the current and the next count.
  always_comb begin
    cnt_max = 1'b1;
    nxt_max = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[k] != BCD_MAX)     cnt_max = 1'b0;
      if (bcd_nxt[k] != BCD_MAX) nxt_max = 1'b0;
    end
  end
  assign cnt_zero = (bcd == '0);
  assign nxt_zero = (bcd_nxt == '0);

  // Control FSM next state, prescaler and count mode.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    down_d  = down_q;
    if (i_Clear || i_Load) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (i_Stop && state_q == RUN) begin
      state_d = PAUSE;
    end else if (i_Start && (state_q == IDLE || state_q == PAUSE)) begin
      down_d = i_Down;
      if (state_q == IDLE) presc_d = '0;
      // Already at the terminal count for the chosen direction: finish at once.
      state_d = (i_Down ? cnt_zero : cnt_max) ? DONE : RUN;
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        // A carry out of the top digit cannot occur in normal use; treat it as terminal.
        if ((down_q ? nxt_zero : nxt_max) || step[DIGITS]) state_d = DONE;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      down_q  <= down_d;
    end
  end

`ifdef GAME_TIMER_LZB_EN
  logic seen_nz;

  // Blank digits above the most significant non-zero digit; digit 0 always shows.
  always_comb begin
    seen_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd[k] != 4'd0 || k == 0) seen_nz = 1'b1;
      fnd[k] = seen_nz ? seg_decode(bcd[k]) : SEG_BLANK;
    end
  end
`else
  for (genvar k = 0; k < DIGITS; k++) begin : g_fnd
    assign fnd[k] = seg_decode(bcd[k]);
  end
`endif

  assign o_Bcd  = bcd;
  assign o_FND  = fnd;
  assign o_Run  = (state_q == RUN);
  assign o_Done = (state_q == DONE);
  assign o_Tick = tick;

endmodule

// File: tb/tb_game_timer_fnd.sv
// Self-checking bench for game_timer_fnd (DIGITS=3, TICK_CLKS=4).
// Count values expected after each step are queued when a run is started
// and popped as the DUT produces each o_Tick.
module tb_game_timer_fnd;

  localparam int DIGITS    = 3;
  localparam int TICK_CLKS = 4;

  logic                clk = 1'b0;
  logic                rst, start, stop, clear, load, down;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] fnd;
  logic                run, done, tick;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] sb_q[$];

  game_timer_fnd #(.DIGITS(DIGITS), .TICK_CLKS(TICK_CLKS)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Start   (start),
    .i_Stop    (stop),
    .i_Clear   (clear),
    .i_Load    (load),
    .i_LoadVal (load_val),
    .i_Down    (down),
    .o_Bcd     (bcd),
    .o_FND     (fnd),
    .o_Run     (run),
    .o_Done    (done),
    .o_Tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] fnd_exp(input logic [11:0] b);
    logic [20:0] r;
    logic        seen;
    logic [3:0]  d;
    r    = '0;
    seen = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      d = b[4*k +: 4];
`ifdef GAME_TIMER_LZB_EN
      if (d != 4'd0 || k == 0) seen = 1'b1;
`else
      seen = 1'b1;
`endif
      r[7*k +: 7] = seen ? seg(d) : 7'h00;
    end
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_start(input logic d);
    down = d; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic cmd_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic cmd_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic cmd_load(input logic [11:0] v);
    load_val = v; load = 1'b1; step(); load = 1'b0;
  endtask

  // Wait for o_Tick (bounded), check the gap in cycles, then compare the
  // stepped count against the next queued expectation.
  task automatic consume_ticks(input string tag, input int n, input int gap);
    int cyc;
    for (int i = 0; i < n; i++) begin
      cyc = 1;
      while (!tick && cyc < 50) begin
        step();
        cyc++;
      end
      check({tag, "_gap"}, tick ? cyc : 999, gap);
      if (!tick) return;
      step();
      if (sb_q.size() == 0) begin
        check({tag, "_sb_underflow"}, 1, 0);
      end else begin
        check({tag, "_bcd"}, bcd, sb_q.pop_front());
      end
    end
  endtask

  task automatic idle_no_tick(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (tick) seen++;
      step();
    end
    check({tag, "_no_tick"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    down = 1'b0; load_val = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_bcd",  bcd,  12'h000);
    check("rst_fnd",  fnd,  fnd_exp(12'h000));
    check("rst_run",  run,  1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tick", tick, 1'b0);

    // Count up through a carry: 001..010
    cmd_start(1'b0);
    check("up_run", run, 1'b1);
    for (int i = 1; i <= 10; i++) sb_q.push_back(to_bcd(i));
    consume_ticks("up", 10, TICK_CLKS);
    check("up_fnd", fnd, fnd_exp(12'h010));

    // Load 005 and count down to DONE
    cmd_clear();
    check("clr_bcd", bcd, 12'h000);
    check("clr_run", run, 1'b0);
    cmd_load(12'h005);
    check("ld5_bcd", bcd, 12'h005);
    cmd_start(1'b1);
    for (int i = 4; i >= 0; i--) sb_q.push_back(to_bcd(i));
    consume_ticks("down", 5, TICK_CLKS);
    check("down_done", done, 1'b1);
    check("down_run",  run,  1'b0);
    idle_no_tick("down_hold", 10);
    check("down_hold_bcd", bcd, 12'h000);

    // Pause mid-period and resume: prescaler is held
    cmd_clear();
    check("clr2_done", done, 1'b0);
    cmd_start(1'b0);
    step(); step();
    cmd_stop();
    check("pause_run", run, 1'b0);
    idle_no_tick("pause", 20);
    check("pause_bcd", bcd, 12'h000);
    cmd_start(1'b0);
    sb_q.push_back(to_bcd(1));
    consume_ticks("resume", 1, 2);
    sb_q.push_back(to_bcd(2));
    consume_ticks("resume_next", 1, TICK_CLKS);

    // Up to terminal 999
    cmd_load(12'h998);
    cmd_start(1'b0);
    sb_q.push_back(12'h999);
    consume_ticks("term_up", 1, TICK_CLKS);
    check("term_up_done", done, 1'b1);
    idle_no_tick("term_up_hold", 10);
    check("term_up_bcd", bcd, 12'h999);

    // Start already at the terminal count
    cmd_load(12'h000);
    cmd_start(1'b1);
    check("z_down_done", done, 1'b1);
    check("z_down_run",  run,  1'b0);
    idle_no_tick("z_down", 5);
    check("z_down_bcd", bcd, 12'h000);
    cmd_load(12'h999);
    cmd_start(1'b0);
    check("max_up_done", done, 1'b1);
    check("max_up_bcd",  bcd,  12'h999);

    // Clear on the tick cycle wins
    cmd_clear();
    cmd_start(1'b0);
    cyc = 1;
    while (!tick && cyc < 50) begin
      step();
      cyc++;
    end
    check("clr_tick_gap", tick ? cyc : 999, TICK_CLKS);
    clear = 1'b1;
    #1;
    check("clr_tick_tick", tick, 1'b0);
    step();
    clear = 1'b0;
    check("clr_tick_bcd",  bcd,  12'h000);
    check("clr_tick_run",  run,  1'b0);
    check("clr_tick_done", done, 1'b0);

    // Load clamp and display patterns
    cmd_load(12'hF3A);
    check("clamp_bcd", bcd, 12'h939);
    check("clamp_fnd", fnd, fnd_exp(12'h939));
    cmd_load(12'h007);
    check("fnd_007", fnd, fnd_exp(12'h007));
    cmd_load(12'h040);
    check("fnd_040", fnd, fnd_exp(12'h040));
    cmd_load(12'h000);
    check("fnd_000", fnd, fnd_exp(12'h000));

    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
